// File: rtl/rotozoom_param_if.sv
// Bundle between the frame timing / table side and the rotozoom parameter
// sequencer. The master drives frame timing and table outputs; the slave
// (the sequencer) drives table indices and the committed parameter set.
interface rotozoom_param_if;
  logic               frame_start;
  logic               run;
  logic signed [15:0] sin_val;
  logic signed [15:0] cos_val;
  logic signed [15:0] scale_val;
  logic [7:0]         trig_idx;
  logic [7:0]         scale_idx;
  logic [16:0]        u_stride;
  logic [16:0]        v_stride;
  logic [16:0]        u_start;
  logic [16:0]        v_start;
  logic               params_valid;
  logic               busy;
  logic               overrun;

  modport master (
    output frame_start, run, sin_val, cos_val, scale_val,
    input  trig_idx, scale_idx, u_stride, v_stride, u_start, v_start,
           params_valid, busy, overrun
  );

  modport slave (
    input  frame_start, run, sin_val, cos_val, scale_val,
    output trig_idx, scale_idx, u_stride, v_stride, u_start, v_start,
           params_valid, busy, overrun
  );
endinterface

// File: rtl/rotozoom_param_sequencer.sv
// Per-frame parameter controller for the rotozoomer. Owns the animation angle,
// drives the table indices, and time-multiplexes one signed 16x16 multiplier
// to build strides and line-start offsets, committing all four at once.
//
// state  | meaning
// IDLE   | waiting for frame_start
// LATCH  | capture table outputs, advance angle when running
// M_US   | multiply scale*cos
// M_VS   | multiply scale*sin, capture u stride
// M_UO   | multiply CENTRE_X*cos, capture v stride
// M_VO   | multiply CENTRE_Y*sin, capture u offset
// DRAIN  | capture v offset
// COMMIT | publish the parameter set, pulse params_valid
module rotozoom_param_sequencer #(
  parameter int CENTRE_X = 320,
  parameter int CENTRE_Y = 240,
  parameter int SHIFT    = 21
) (
  input logic              clk,
  input logic              rst,
  rotozoom_param_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LATCH, M_US, M_VS, M_UO, M_VO, DRAIN, COMMIT
  } state_t;

  // Centre constants are zero-extended into the signed 16-bit operand space.
  localparam logic signed [15:0] CX = 16'(CENTRE_X);
  localparam logic signed [15:0] CY = 16'(CENTRE_Y);

  state_t             state;
  logic [8:0]         angle;
  logic signed [15:0] sin_r, cos_r, scale_r;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] prod;
  logic [16:0]        prod_q;
  logic [16:0]        us_t, vs_t, uo_t, vo_t;
  logic [16:0]        u_stride, v_stride, u_start, v_start;
  logic               params_valid, busy, overrun;

  assign prod_q = 17'(prod >>> SHIFT);

  // Operand select for the shared multiplier, one product per cycle.
  always_comb begin
    mul_a = scale_r;
    mul_b = cos_r;
    case (state)
      M_VS: begin mul_a = scale_r; mul_b = sin_r; end
      M_UO: begin mul_a = CX;      mul_b = cos_r; end
      M_VO: begin mul_a = CY;      mul_b = sin_r; end
      default: ;
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      angle        <= '0;
      sin_r        <= '0;
      cos_r        <= '0;
      scale_r      <= '0;
      prod         <= '0;
      us_t         <= '0;
      vs_t         <= '0;
      uo_t         <= '0;
      vo_t         <= '0;
      u_stride     <= '0;
      v_stride     <= '0;
      u_start      <= '0;
      v_start      <= '0;
      params_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      params_valid <= 1'b0;
      // A frame_start while a sequence is in flight (COMMIT included) is dropped.
      if (bus.frame_start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state <= LATCH;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          sin_r   <= bus.sin_val;
          cos_r   <= bus.cos_val;
          scale_r <= bus.scale_val;
          if (bus.run) angle <= angle + 9'd1;
          state <= M_US;
        end
        M_US: begin
          prod  <= mul_a * mul_b;
          state <= M_VS;
        end
        M_VS: begin
          prod  <= mul_a * mul_b;
          us_t  <= prod_q;
          state <= M_UO;
        end
        M_UO: begin
          prod  <= mul_a * mul_b;
          vs_t  <= prod_q;
          state <= M_VO;
        end
        M_VO: begin
          prod  <= mul_a * mul_b;
          uo_t  <= prod_q;
          state <= DRAIN;
        end
        DRAIN: begin
          vo_t  <= prod_q;
          state <= COMMIT;
        end
        COMMIT: begin
          u_stride     <= us_t;
          v_stride     <= vs_t;
          u_start      <= 17'(-uo_t);
          v_start      <= vo_t;
          params_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trig_idx     = angle[7:0];
  assign bus.scale_idx    = angle[8:1];
  assign bus.u_stride     = u_stride;
  assign bus.v_stride     = v_stride;
  assign bus.u_start      = u_start;
  assign bus.v_start      = v_start;
  assign bus.params_valid = params_valid;
  assign bus.busy         = busy;
  assign bus.overrun      = overrun;

endmodule

// File: tb/tb_rotozoom_param_sequencer.sv
// Scoreboard bench for rotozoom_param_sequencer: the driver predicts each
// frame's parameter set from the arithmetic rules and queues it; the monitor
// checks every params_valid commit against the queue head.
module tb_rotozoom_param_sequencer;
  localparam int CX = 320;
  localparam int CY = 240;
  localparam int SH = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  rotozoom_param_if bus ();

  rotozoom_param_sequencer #(.CENTRE_X(CX), .CENTRE_Y(CY), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] us, vs, uo, vo;
    logic [7:0]  ti, si;
    int          cyc_exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_angle = 0;
  int   pv_count = 0;
  logic pv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // floor(p / 2^SH) reduced mod 2^17
  function automatic logic [16:0] scaled(input longint p);
    longint d, q;
    d = longint'(1) << SH;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    return q[16:0];
  endfunction

  // Issue one frame_start with the given table outputs, queue the prediction.
  task automatic do_frame(input logic rn, input logic signed [15:0] s,
                          input logic signed [15:0] c, input logic signed [15:0] sc,
                          input int gap);
    exp_t e;
    logic [16:0] uo;
    @(negedge clk);
    bus.run = rn; bus.sin_val = s; bus.cos_val = c; bus.scale_val = sc;
    bus.frame_start = 1'b1;
    if (rn) m_angle = (m_angle + 1) % 512;
    e.us = scaled(longint'(sc) * longint'(c));
    e.vs = scaled(longint'(sc) * longint'(s));
    uo   = scaled(longint'(CX) * longint'(c));
    e.uo = 17'(-uo);
    e.vo = scaled(longint'(CY) * longint'(s));
    e.ti = 8'(m_angle % 256);
    e.si = 8'(m_angle / 2);
    e.cyc_exp = cyc + 8;
    sb.push_back(e);
    @(negedge clk);
    bus.frame_start = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_u_stride"}, 32'(bus.u_stride), 0);
    chk({nm, "_v_stride"}, 32'(bus.v_stride), 0);
    chk({nm, "_u_start"},  32'(bus.u_start), 0);
    chk({nm, "_v_start"},  32'(bus.v_start), 0);
    chk({nm, "_trig_idx"}, 32'(bus.trig_idx), 0);
    chk({nm, "_scale_idx"}, 32'(bus.scale_idx), 0);
    chk({nm, "_pv"},   32'(bus.params_valid), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
  endtask

  // Monitor: compare each commit against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      pv_prev <= 1'b0;
    end else begin
      pv_prev <= bus.params_valid;
      if (pv_prev && bus.params_valid) chk("pv_width", 32'(bus.params_valid), 0);
      if (bus.params_valid) begin
        pv_count++;
        if (sb.size() == 0) begin
          chk("unexpected_commit", 32'(bus.params_valid), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("commit_cycle", 32'(cyc), 32'(e.cyc_exp));
          chk("u_stride", 32'(bus.u_stride), 32'(e.us));
          chk("v_stride", 32'(bus.v_stride), 32'(e.vs));
          chk("u_start",  32'(bus.u_start),  32'(e.uo));
          chk("v_start",  32'(bus.v_start),  32'(e.vo));
          chk("trig_idx", 32'(bus.trig_idx), 32'(e.ti));
          chk("scale_idx", 32'(bus.scale_idx), 32'(e.si));
          chk("busy_at_commit", 32'(bus.busy), 0);
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc_exp) begin
        chk("commit_timeout", 32'(bus.params_valid), 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int pv_base;
    int n;
    bus.frame_start = 1'b0; bus.run = 1'b0;
    bus.sin_val = '0; bus.cos_val = '0; bus.scale_val = '0;

    // Reset held while inputs toggle.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.frame_start = i[0]; bus.run = 1'b1;
      bus.sin_val = 16'($urandom); bus.cos_val = 16'($urandom);
      bus.scale_val = 16'($urandom);
    end
    @(negedge clk);
    chk_zero("in_reset");
    chk("in_reset_overrun", 32'(bus.overrun), 0);
    bus.frame_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero("post_reset");

    // Basic compute and negative operands.
    do_frame(1'b1, 16'sh0000, 16'sh7FFF, 16'sh4000, 10);
    wait_drain();
    chk("basic_trig_idx", 32'(bus.trig_idx), 1);
    chk("basic_u_start", 32'(bus.u_start), 32'h1FFFC);
    chk("basic_u_stride", 32'(bus.u_stride), 255);
    do_frame(1'b1, 16'sh8000, 16'sh8000, 16'sh4000, 10);
    wait_drain();
    chk("neg_u_stride", 32'(bus.u_stride), 32'h1FF00);
    chk("neg_u_start", 32'(bus.u_start), 5);
    chk("overrun_clear", 32'(bus.overrun), 0);

    // Overrun: second pulse 3 cycles after the first is ignored.
    @(negedge clk);
    do_frame(1'b1, 16'sh1234, 16'sh4321, 16'sh2000, 3);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("overrun_set", 32'(bus.overrun), 1);
    do_frame(1'b0, 16'sh0100, 16'shF000, 16'sh7000, 10);
    wait_drain();
    chk("overrun_sticky", 32'(bus.overrun), 1);

    // Reset in M_VO aborts the sequence.
    do_frame(1'b1, 16'sh3000, 16'sh3000, 16'sh3000, 5);
    rst = 1'b1;
    sb.delete();
    m_angle = 0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_reset_no_commit", 32'(bus.params_valid), 0);
    do_frame(1'b1, 16'sh0800, 16'shC000, 16'sh5000, 10);
    wait_drain();

    // Randomized frames.
    for (int i = 0; i < 40; i++) begin
      do_frame(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               int'($urandom_range(8, 14)));
    end
    wait_drain();

    // Walk the angle up to 511, then wrap.
    n = 0;
    while (m_angle != 511 && n < 520) begin
      do_frame(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 8);
      n++;
    end
    wait_drain();
    chk("angle_511_trig", 32'(bus.trig_idx), 255);
    chk("angle_511_scale", 32'(bus.scale_idx), 255);
    do_frame(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 10);
    wait_drain();
    chk("angle_wrap_trig", 32'(bus.trig_idx), 0);

    // Frozen animation still recomputes every frame.
    pv_base = pv_count;
    for (int i = 0; i < 3; i++)
      do_frame(1'b0, 16'($urandom), 16'($urandom), 16'($urandom), 10);
    wait_drain();
    chk("freeze_pulses", 32'(pv_count - pv_base), 3);
    chk("freeze_trig", 32'(bus.trig_idx), 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
